// File: rtl/servo_track_ctrl_if.sv
// rtl/servo_track_ctrl_if.sv - servo-tracking ADC loop controller signal bundle
interface servo_track_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             Enable;
  logic             CompIn;
  logic             UpOrDown;
  logic             StepEn;
  logic [WIDTH-1:0] Code;
  logic             Locked;
  logic             OverRange;
  logic             UnderRange;
  logic [WIDTH-1:0] DataOut;
  logic             DataValid;

  // Controller side: takes enable and comparator, drives counter and result.
  modport master (
    input  Enable, CompIn,
    output UpOrDown, StepEn, Code, Locked, OverRange, UnderRange, DataOut, DataValid
  );

  // Host/analog side: drives enable and comparator, observes everything else.
  modport slave (
    output Enable, CompIn,
    input  UpOrDown, StepEn, Code, Locked, OverRange, UnderRange, DataOut, DataValid
  );
endinterface

// File: rtl/servo_track_ctrl.sv
// rtl/servo_track_ctrl.sv - servo-tracking ADC loop controller; SERVO_LOCK_FILTER_EN publishes the lower dither code
module servo_track_ctrl #(
  parameter int WIDTH          = 4,
  parameter int SETTLE_CYCLES  = 3,
  parameter int LOCK_REVERSALS = 2
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  servo_track_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CODE_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CODE_ZERO   = {WIDTH{1'b0}};
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       REV_MAX     = 3'(LOCK_REVERSALS);

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [3:0]       settle_q;
  logic             up_q;
  logic             step_q;
  logic [WIDTH-1:0] code_q;
  logic             locked_q;
  logic             over_q;
  logic             under_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic [2:0]       rev_q;
  logic             prev_dir_q;
  logic             prev_valid_q;

  logic             cs;
  logic [WIDTH-1:0] code_d;
  logic [2:0]       rev_d;
  logic             lock_d;
  logic [WIDTH-1:0] pub_d;
  logic             clip_hi;
  logic             clip_lo;

  assign cs = sync_q[1];

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.CompIn};
    end
  end

  // Next code, reversal tracking and publish value for the step in flight (direction is up_q).
  always_comb begin
    code_d  = up_q ? code_q + 1'b1 : code_q - 1'b1;
    rev_d   = 3'd0;
    if (prev_valid_q && (up_q != prev_dir_q)) begin
      rev_d = (rev_q == REV_MAX) ? rev_q : rev_q + 3'd1;
    end
    lock_d  = (rev_d == REV_MAX);
`ifdef SERVO_LOCK_FILTER_EN
    // Lower code of the dither pair: pre-step code when stepping up, post-step when stepping down.
    pub_d   = up_q ? code_q : code_d;
`else
    pub_d   = code_q;
`endif
    clip_hi = cs && (code_q == CODE_MAX);
    clip_lo = !cs && (code_q == CODE_ZERO);
  end

  // Tracking FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      settle_q     <= 4'd0;
      up_q         <= 1'b1;
      step_q       <= 1'b0;
      code_q       <= CODE_ZERO;
      locked_q     <= 1'b0;
      over_q       <= 1'b0;
      under_q      <= 1'b0;
      dout_q       <= CODE_ZERO;
      valid_q      <= 1'b0;
      rev_q        <= 3'd0;
      prev_dir_q   <= 1'b0;
      prev_valid_q <= 1'b0;
    end else if (!bus.Enable) begin
      // The strobe for a STEP already went out this cycle, so the counter moves on this edge;
      // keep the mirror in step with it even though tracking stops here.
      if (state_q == S_STEP) begin
        code_q <= code_d;
      end
      state_q  <= S_IDLE;
      step_q   <= 1'b0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      rev_q    <= 3'd0;
    end else begin
      step_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q  <= S_SETTLE;
          settle_q <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          if (settle_q == 4'd0) begin
            state_q <= S_SAMPLE;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (clip_hi || clip_lo) begin
            // At a rail: publish the clipped code and hold there without stepping.
            over_q   <= clip_hi;
            under_q  <= clip_lo;
            locked_q <= 1'b1;
            dout_q   <= code_q;
            valid_q  <= 1'b1;
            state_q  <= S_SETTLE;
            settle_q <= SETTLE_LOAD;
          end else begin
            over_q  <= 1'b0;
            under_q <= 1'b0;
            up_q    <= cs;
            step_q  <= 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          code_q       <= code_d;
          rev_q        <= rev_d;
          locked_q     <= lock_d;
          prev_dir_q   <= up_q;
          prev_valid_q <= 1'b1;
          if (lock_d) begin
            dout_q  <= pub_d;
            valid_q <= 1'b1;
          end
          state_q  <= S_SETTLE;
          settle_q <= SETTLE_LOAD;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.UpOrDown   = up_q;
  assign bus.StepEn     = step_q;
  assign bus.Code       = code_q;
  assign bus.Locked     = locked_q;
  assign bus.OverRange  = over_q;
  assign bus.UnderRange = under_q;
  assign bus.DataOut    = dout_q;
  assign bus.DataValid  = valid_q;

endmodule

// File: tb/tb_servo_track_ctrl.sv
// tb/tb_servo_track_ctrl.sv - directed bench for servo_track_ctrl with an external counter and Vin model
module tb_servo_track_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] cnt_m;
  logic       vin_mode;
  int         n_chk;
  int         n_pass;
  int         lock_exp[4];

  servo_track_ctrl_if #(.WIDTH(4)) bus ();

  servo_track_ctrl #(
    .WIDTH(4),
    .SETTLE_CYCLES(3),
    .LOCK_REVERSALS(2)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The up/down counter the controller drives.
  always @(posedge clk) begin
    if (!rst_n) cnt_m <= 4'd0;
    else if (bus.StepEn) cnt_m <= bus.UpOrDown ? cnt_m + 4'd1 : cnt_m - 4'd1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock; outputs sampled 1 ns after the edge, Vin=9.5 comparator model refreshed.
  task automatic tick();
    @(posedge clk);
    #1;
    if (vin_mode) bus.CompIn = (cnt_m <= 4'd9);
  endtask

  // Ticks until StepEn is seen; n = ticks taken, -1 on timeout.
  task automatic wait_step(output int n);
    n = 0;
    while (!bus.StepEn && n < 40) begin
      tick();
      n++;
    end
    if (!bus.StepEn) n = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int steps;
    int pubs;
    int locked_early;
    int stepen_cnt;
    int last_dv;
    int zero_seen;
    int bad_dir;
    n_chk = 0;
    n_pass = 0;
`ifdef SERVO_LOCK_FILTER_EN
    lock_exp = '{9, 9, 9, 9};
`else
    lock_exp = '{9, 10, 9, 10};
`endif
    vin_mode   = 1'b0;
    rst_n      = 1'b0;
    bus.Enable = 1'b1;
    bus.CompIn = 1'b1;
    tick();
    tick();
    chk("rst_code", bus.Code, 0);
    chk("rst_dout", bus.DataOut, 0);
    chk("rst_updown", bus.UpOrDown, 1);
    chk("rst_stepen", bus.StepEn, 0);
    chk("rst_locked", bus.Locked, 0);
    chk("rst_over", bus.OverRange, 0);
    chk("rst_under", bus.UnderRange, 0);
    chk("rst_valid", bus.DataValid, 0);

    // Ramp up: StepEn lands in the 6th cycle after enable, then every 5 cycles.
    rst_n = 1'b1;
    wait_step(n);
    chk("first_step_lat", n, 5);
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("ramp_dir_%0d", i), bus.UpOrDown, 1);
      tick();
      chk($sformatf("ramp_code_%0d", i), bus.Code, i);
      chk($sformatf("ramp_cnt_%0d", i), cnt_m, i);
      chk($sformatf("ramp_locked_%0d", i), bus.Locked, 0);
      if (i < 15) begin
        wait_step(n);
        chk($sformatf("ramp_period_%0d", i), n, 4);
      end
    end

    // Saturation at 15: no steps, clip publishes every 4 cycles.
    stepen_cnt = 0;
    last_dv    = -1;
    zero_seen  = 0;
    for (int t = 0; t < 24; t++) begin
      tick();
      if (bus.StepEn) stepen_cnt++;
      if (bus.Code == 4'd0) zero_seen = 1;
      if (bus.DataValid) begin
        chk("sat_dout", bus.DataOut, 15);
        if (last_dv >= 0) chk("sat_dv_period", t - last_dv, 4);
        last_dv = t;
      end
    end
    chk("sat_no_step", stepen_cnt, 0);
    chk("sat_dv_seen", (last_dv >= 0) ? 1 : 0, 1);
    chk("sat_over", bus.OverRange, 1);
    chk("sat_under", bus.UnderRange, 0);
    chk("sat_locked", bus.Locked, 1);
    chk("sat_zero_seen", zero_seen, 0);
    chk("sat_cnt", cnt_m, 15);

    // Lock around Vin=9.5 from Code=0.
    rst_n = 1'b0;
    tick();
    tick();
    vin_mode   = 1'b1;
    bus.CompIn = 1'b1;
    rst_n      = 1'b1;
    steps = 0;
    pubs = 0;
    locked_early = 0;
    for (int t = 0; t < 400 && pubs < 4; t++) begin
      tick();
      if (bus.StepEn) steps++;
      if (bus.Locked && steps < 12) locked_early = 1;
      if (bus.DataValid) begin
        chk($sformatf("lock_dout_%0d", pubs), bus.DataOut, lock_exp[pubs]);
        chk($sformatf("lock_flag_%0d", pubs), bus.Locked, 1);
        chk($sformatf("lock_code_%0d", pubs), bus.Code, cnt_m);
        if (pubs == 0) chk("lock_steps_to_lock", steps, 12);
        pubs++;
      end
    end
    chk("lock_pubs", pubs, 4);
    chk("lock_early", locked_early, 0);
    chk("lock_end_code", bus.Code, 9);

    // Underrange: force CompIn=0 from locked Code=9.
    vin_mode   = 1'b0;
    bus.CompIn = 1'b0;
    wait_step(n);
    chk("under_first_lat", n, 4);
    chk("under_first_dir", bus.UpOrDown, 0);
    tick();
    chk("under_unlock", bus.Locked, 0);
    chk("under_code8", bus.Code, 8);
    steps = 1;
    bad_dir = 0;
    for (int t = 0; t < 200 && !bus.DataValid; t++) begin
      tick();
      if (bus.StepEn) begin
        steps++;
        if (bus.UpOrDown) bad_dir++;
      end
    end
    chk("under_steps", steps, 9);
    chk("under_bad_dir", bad_dir, 0);
    chk("under_valid", bus.DataValid, 1);
    chk("under_dout", bus.DataOut, 0);
    chk("under_flag", bus.UnderRange, 1);
    chk("under_over", bus.OverRange, 0);
    chk("under_locked", bus.Locked, 1);
    chk("under_code", bus.Code, 0);

    // Enable drop mid-SETTLE at Code=6, then resume.
    bus.CompIn = 1'b1;
    for (int t = 0; t < 200 && cnt_m != 4'd6; t++) tick();
    chk("drop_reach6", cnt_m, 6);
    bus.Enable = 1'b0;
    tick();
    chk("drop_stepen", bus.StepEn, 0);
    chk("drop_locked", bus.Locked, 0);
    chk("drop_code", bus.Code, 6);
    stepen_cnt = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (bus.StepEn) stepen_cnt++;
    end
    chk("drop_no_step", stepen_cnt, 0);
    chk("drop_hold_code", bus.Code, 6);
    bus.Enable = 1'b1;
    wait_step(n);
    chk("resume_lat", n, 5);
    chk("resume_dir", bus.UpOrDown, 1);
    tick();
    chk("resume_code", bus.Code, 7);
    chk("resume_cnt", cnt_m, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
